// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU and the status stage that consumes its result.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // A shift count is taken from the low bits of operand B.
  localparam int SHAMT_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier. The parent loads the operands once and then
// pulses step once per cycle. After WIDTH steps the accumulator holds the full
// 2*WIDTH-bit product.
// The next accumulator value is exported so the parent can register the
// final product on the same edge as the last step.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     partial;

  // One step: conditionally add the multiplicand into the upper half, then
  // shift the whole accumulator right. The carry goes into the top bit.
  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  // The accumulator starts with the multiplier in its low half.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mcand_q <= '0;
    end else if (load) begin
      mcand_q <= mcand;
      acc     <= {{WIDTH{1'b0}}, mplier};
    end else if (step) begin
      acc     <= acc_next;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Sequential ALU. It runs one operation per accepted start pulse.
// Logic ops and add/sub finish in one cycle. Shifts advance one bit per cycle.
// MUL takes WIDTH shift-add steps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; accepts start
// RUN     | multi-cycle op in progress; start ignored; counter counts down
// DONE    | one-cycle result strobe; accepts a back-to-back start
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUComputedValue,
  output logic             overflow
);

  // The counter must be able to hold both WIDTH (MUL) and the largest shift count.
  localparam int CNT_W = ($clog2(WIDTH+1) > SHAMT_W) ? $clog2(WIDTH+1) : SHAMT_W;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   count;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   sh_q, sh_next;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   quick_res;
  logic               quick_ovf;
  logic               is_shift, needs_run;
  logic               accept, direct, last_step;
  logic               mul_load, mul_step;
  logic [2*WIDTH-1:0] mul_next;

  assign shamt     = SHAMT_W'(operandB);
  assign sum       = operandA + operandB;
  assign diff      = operandA - operandB;
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
  assign needs_run = (is_shift && (shamt != '0)) || (op == OP_MUL);

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign mul_load = accept && (op == OP_MUL);
  assign mul_step = (state == ST_RUN) && (op_q == OP_MUL);
  assign sh_next  = (op_q == OP_SHL) ? (sh_q << 1) : (sh_q >> 1);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock    (clock),
    .reset    (reset),
    .load     (mul_load),
    .step     (mul_step),
    .mcand    (operandA),
    .mplier   (operandB),
    .acc_next (mul_next)
  );

  // Single-cycle results, computed straight from the operands at start.
  // A shift by zero passes A through unchanged.
  always_comb begin
    quick_res = '0;
    quick_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        quick_res = sum;
        quick_ovf = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                    (sum[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        quick_res = diff;
        quick_ovf = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                    (diff[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_AND:         quick_res = operandA & operandB;
      OP_OR:          quick_res = operandA | operandB;
      OP_XOR:         quick_res = operandA ^ operandB;
      OP_NOT:         quick_res = ~operandA;
      OP_SHL, OP_SHR: quick_res = operandA;
      default:        ;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. RUN leaves on the terminal count of 1, which is the last step.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    direct    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept = 1'b1;
          if (needs_run) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
            direct    = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, step counter and shifter, plus the output registers.
  // The output registers change only on the edge that enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count            <= '0;
      op_q             <= '0;
      sh_q             <= '0;
      ALUComputedValue <= '0;
      overflow         <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op;
        sh_q  <= operandA;
        count <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
      end else if (state == ST_RUN) begin
        count <= count - 1'b1;
        sh_q  <= sh_next;
      end

      if (direct) begin
        ALUComputedValue <= quick_res;
        overflow         <= quick_ovf;
      end else if (last_step) begin
        if (op_q == OP_MUL) begin
          ALUComputedValue <= mul_next[WIDTH-1:0];
          overflow         <= |mul_next[2*WIDTH-1:WIDTH];
        end else begin
          ALUComputedValue <= sh_next;
          overflow         <= 1'b0;
        end
      end
    end
  end

endmodule
